// File: rtl/cache_refill_ctrl_if.sv
// Signal bundle between the cache core/arrays, main memory and the refill controller.
// The controller takes the master modport; the core/memory side takes slave.
interface cache_refill_ctrl_if #(
   parameter int ADDR_WIDTH     = 32,
   parameter int LINE_WIDTH     = 128,
   parameter int MEM_DATA_WIDTH = 32,
   parameter int WAY_NUM        = 2
);
   logic                      cache_en;
   logic [ADDR_WIDTH-1:0]     cachein_addr;
   logic [WAY_NUM-1:0]        hit_en;
   logic                      stall;

   logic                      mem_req;
   logic [ADDR_WIDTH-1:0]     mem_addr;
   logic                      mem_gnt;
   logic                      mem_rvalid;
   logic [MEM_DATA_WIDTH-1:0] mem_rdata;

   logic                      refill_we;
   logic [WAY_NUM-1:0]        refill_way;
   logic [ADDR_WIDTH-1:0]     refill_addr;
   logic [LINE_WIDTH-1:0]     refill_data;
   logic                      refill_done;
   logic                      refill_err;

   modport master (
      input  cache_en, cachein_addr, hit_en, mem_gnt, mem_rvalid, mem_rdata,
      output stall, mem_req, mem_addr,
      output refill_we, refill_way, refill_addr, refill_data, refill_done, refill_err
   );

   modport slave (
      output cache_en, cachein_addr, hit_en, mem_gnt, mem_rvalid, mem_rdata,
      input  stall, mem_req, mem_addr,
      input  refill_we, refill_way, refill_addr, refill_data, refill_done, refill_err
   );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache-miss refill controller: line request, multi-beat fill, round-robin victim write.
// Optional refill watchdog enabled by defining CACHE_REFILL_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | no refill in progress; a miss latches the line address
// S_REQ   | mem_req high with line address, waiting for mem_gnt
// S_FILL  | collecting BEATS read beats into the line buffer
// S_WRITE | one cycle: write assembled line into the victim way
module cache_refill_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int LINE_WIDTH     = 128,
   parameter int MEM_DATA_WIDTH = 32,
   parameter int WAY_NUM        = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   cache_refill_ctrl_if.master bus
);

   localparam int BEATS       = LINE_WIDTH / MEM_DATA_WIDTH;
   localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
   localparam int BC_W        = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int RR_W        = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
   localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
      ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_FILL  = 2'd2;
   localparam logic [1:0] S_WRITE = 2'd3;

   if ((LINE_WIDTH % MEM_DATA_WIDTH) != 0 || WAY_NUM < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("cache_refill_ctrl: unsupported parameter combination");
   end

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [ADDR_WIDTH-1:0] line_addr;
   logic [LINE_WIDTH-1:0] line_buf;
   logic [LINE_WIDTH-1:0] line_nxt;
   logic [BC_W-1:0]       beat_cnt;
   logic [RR_W-1:0]       rr_ptr;
   logic [ADDR_WIDTH-1:0] refill_addr_q;
   logic [LINE_WIDTH-1:0] refill_data_q;
   logic [WAY_NUM-1:0]    way_oh;
   logic                  miss;
   logic                  beat_take;
   logic                  last_beat;
   logic                  abort;

   assign miss      = bus.cache_en & (bus.hit_en == '0);
   assign beat_take = (state == S_FILL) & bus.mem_rvalid;
   assign last_beat = beat_take & (beat_cnt == BC_W'(BEATS - 1));

   always_comb begin
      line_nxt = line_buf;
      for (int b = 0; b < BEATS; b++) begin
         if (beat_take && (beat_cnt == BC_W'(b))) begin
            line_nxt[b*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = bus.mem_rdata;
         end
      end
   end

`ifdef CACHE_REFILL_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;
   logic            err_q;

   // wd_cnt counts completed REQ/FILL cycles; abort on the TIMEOUT_CYCLES-th one
   assign abort = ((state == S_REQ) | (state == S_FILL)) &
                  (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= abort;
         if (state == S_IDLE) begin
            wd_cnt <= '0;
         end else if ((state == S_REQ) || (state == S_FILL)) begin
            wd_cnt <= wd_cnt + WD_W'(1);
         end
      end
   end

   assign bus.refill_err = err_q;
`else
   assign abort          = 1'b0;
   assign bus.refill_err = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (miss) state_nxt = S_REQ;
         end
         S_REQ: begin
            if (abort)            state_nxt = S_IDLE;
            else if (bus.mem_gnt) state_nxt = S_FILL;
         end
         S_FILL: begin
            if (abort)          state_nxt = S_IDLE;
            else if (last_beat) state_nxt = S_WRITE;
         end
         S_WRITE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         line_addr     <= '0;
         line_buf      <= '0;
         beat_cnt      <= '0;
         rr_ptr        <= '0;
         refill_addr_q <= '0;
         refill_data_q <= '0;
      end else begin
         state    <= state_nxt;
         line_buf <= line_nxt;
         if ((state == S_IDLE) && miss) begin
            line_addr <= bus.cachein_addr & ~OFFSET_MASK;
         end
         if (state == S_REQ) begin
            beat_cnt <= '0;
         end else if (beat_take) begin
            beat_cnt <= beat_cnt + BC_W'(1);
         end
         // Output copies load only on a completed fill, so they hold between refills
         if (last_beat && !abort) begin
            refill_addr_q <= line_addr;
            refill_data_q <= line_nxt;
         end
         if (state == S_WRITE) begin
            rr_ptr <= (rr_ptr == RR_W'(WAY_NUM - 1)) ? '0 : rr_ptr + RR_W'(1);
         end
      end
   end

   always_comb begin
      way_oh = '0;
      for (int w = 0; w < WAY_NUM; w++) begin
         way_oh[w] = (state == S_WRITE) && (rr_ptr == RR_W'(w));
      end
   end

   assign bus.stall       = (state != S_IDLE) | miss;
   assign bus.mem_req     = (state == S_REQ);
   assign bus.mem_addr    = line_addr;
   assign bus.refill_we   = (state == S_WRITE);
   assign bus.refill_done = (state == S_WRITE);
   assign bus.refill_way  = way_oh;
   assign bus.refill_addr = refill_addr_q;
   assign bus.refill_data = refill_data_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl; refill watchdog scenario runs when CACHE_REFILL_TIMEOUT_EN is defined.
module tb_cache_refill_ctrl;
   localparam int AW  = 32;
   localparam int LW  = 128;
   localparam int MDW = 32;
   localparam int WN  = 2;
`ifdef CACHE_REFILL_TIMEOUT_EN
   localparam int TO  = 10;
`else
   localparam int TO  = 255;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] beats [4];
   int          gaps  [4];

   cache_refill_ctrl_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MEM_DATA_WIDTH(MDW), .WAY_NUM(WN)) bus_if ();

   cache_refill_ctrl #(
      .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MEM_DATA_WIDTH(MDW), .WAY_NUM(WN), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #4 rst_n = 1'b1;
   endtask

   // One full refill; returns 2 ns after the edge that entered WRITE, with WRITE checked.
   task automatic do_refill(input logic [31:0] addr, input int gnt_wait, input bit spurious,
                            input logic [1:0] exp_way, input string tag);
      logic [31:0]  la;
      logic [127:0] exp_line;
      la       = addr & 32'hFFFF_FFF0;
      exp_line = {beats[3], beats[2], beats[1], beats[0]};

      step();
      bus_if.cache_en = 1'b1; bus_if.cachein_addr = addr; bus_if.hit_en = 2'b00;
      bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0;
      #1;
      checks++;
      if (bus_if.stall !== 1'b1 || bus_if.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL %s miss_cycle stall=%0b mem_req=%0b exp stall=1 mem_req=0", tag, bus_if.stall, bus_if.mem_req);
      end

      for (int c = 0; c < gnt_wait; c++) begin
         step();
         bus_if.cache_en   = 1'b0;
         bus_if.mem_gnt    = (c == gnt_wait - 1);
         bus_if.mem_rvalid = spurious && (c == 0);
         bus_if.mem_rdata  = 32'hDEAD_BEEF;
         #1;
         checks++;
         if (bus_if.mem_req !== 1'b1 || bus_if.mem_addr !== la || bus_if.stall !== 1'b1) begin
            errors++;
            $display("FAIL %s req_cycle%0d mem_req=%0b mem_addr=%h stall=%0b exp 1 %h 1",
                     tag, c, bus_if.mem_req, bus_if.mem_addr, bus_if.stall, la);
         end
      end

      for (int b = 0; b < 4; b++) begin
         for (int g = 0; g < gaps[b]; g++) begin
            step();
            bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0; bus_if.mem_rdata = 32'hBAD0_0000;
            bus_if.cache_en = 1'b1; bus_if.cachein_addr = 32'hFFFF_FFF4; bus_if.hit_en = 2'b00;
            #1;
            checks++;
            if (bus_if.mem_req !== 1'b0 || bus_if.stall !== 1'b1 || bus_if.refill_we !== 1'b0) begin
               errors++;
               $display("FAIL %s gap b%0d g%0d mem_req=%0b stall=%0b we=%0b exp 0 1 0",
                        tag, b, g, bus_if.mem_req, bus_if.stall, bus_if.refill_we);
            end
         end
         step();
         bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = beats[b];
         bus_if.cache_en = 1'b0;
         #1;
         checks++;
         if (bus_if.mem_req !== 1'b0 || bus_if.refill_we !== 1'b0) begin
            errors++;
            $display("FAIL %s beat%0d mem_req=%0b we=%0b exp 0 0", tag, b, bus_if.mem_req, bus_if.refill_we);
         end
      end

      step();
      bus_if.mem_rvalid = 1'b0; bus_if.cache_en = 1'b0;
      #1;
      checks++;
      if (bus_if.refill_we !== 1'b1 || bus_if.refill_done !== 1'b1 || bus_if.stall !== 1'b1) begin
         errors++;
         $display("FAIL %s write_ctl we=%0b done=%0b stall=%0b exp 1 1 1",
                  tag, bus_if.refill_we, bus_if.refill_done, bus_if.stall);
      end
      checks++;
      if (bus_if.refill_way !== exp_way || bus_if.refill_addr !== la) begin
         errors++;
         $display("FAIL %s write_way_addr way=%b addr=%h exp %b %h", tag, bus_if.refill_way, bus_if.refill_addr, exp_way, la);
      end
      checks++;
      if (bus_if.refill_data !== exp_line) begin
         errors++;
         $display("FAIL %s write_data got %h exp %h", tag, bus_if.refill_data, exp_line);
      end
   endtask

   task automatic test_reset();
      bus_if.cache_en = 1'b0; bus_if.cachein_addr = '0; bus_if.hit_en = '0;
      bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0; bus_if.mem_rdata = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus_if.stall, bus_if.mem_req, bus_if.refill_we, bus_if.refill_done, bus_if.refill_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctl stall/req/we/done/err=%b exp 00000",
                  {bus_if.stall, bus_if.mem_req, bus_if.refill_we, bus_if.refill_done, bus_if.refill_err});
      end
      checks++;
      if (bus_if.mem_addr !== '0 || bus_if.refill_addr !== '0 || bus_if.refill_data !== '0 || bus_if.refill_way !== '0) begin
         errors++;
         $display("FAIL reset_data mem_addr=%h refill_addr=%h way=%b data=%h exp all zero",
                  bus_if.mem_addr, bus_if.refill_addr, bus_if.refill_way, bus_if.refill_data);
      end
      #3 rst_n = 1'b1;
   endtask

   task automatic test_single_refill();
      beats[0] = 32'h1111_1111; beats[1] = 32'h2222_2222; beats[2] = 32'h3333_3333; beats[3] = 32'h4444_4444;
      gaps = '{0, 0, 0, 0};
      do_refill(32'h0000_1234, 3, 1'b0, 2'b01, "single");
      step();
      #1;
      checks++;
      if (bus_if.stall !== 1'b0 || bus_if.refill_we !== 1'b0 || bus_if.refill_done !== 1'b0 || bus_if.refill_way !== 2'b00) begin
         errors++;
         $display("FAIL single_after stall=%0b we=%0b done=%0b way=%b exp 0 0 0 00",
                  bus_if.stall, bus_if.refill_we, bus_if.refill_done, bus_if.refill_way);
      end
      checks++;
      if (bus_if.refill_data !== 128'h44444444_33333333_22222222_11111111 || bus_if.refill_addr !== 32'h0000_1230) begin
         errors++;
         $display("FAIL single_hold data=%h addr=%h", bus_if.refill_data, bus_if.refill_addr);
      end
      step();
      checks++;
      if (bus_if.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL single_no_rereq mem_req=%0b exp 0", bus_if.mem_req);
      end
   endtask

   task automatic test_hit();
      step();
      bus_if.cache_en = 1'b1; bus_if.cachein_addr = 32'h0000_5678; bus_if.hit_en = 2'b10;
      #1;
      checks++;
      if (bus_if.stall !== 1'b0) begin
         errors++;
         $display("FAIL hit_stall got %0b exp 0", bus_if.stall);
      end
      step();
      bus_if.hit_en = 2'b01;
      #1;
      checks++;
      if (bus_if.mem_req !== 1'b0 || bus_if.stall !== 1'b0) begin
         errors++;
         $display("FAIL hit_noreq mem_req=%0b stall=%0b exp 0 0", bus_if.mem_req, bus_if.stall);
      end
      step();
      bus_if.cache_en = 1'b0; bus_if.hit_en = 2'b00;
      #1;
      checks++;
      if (bus_if.mem_req !== 1'b0 || bus_if.stall !== 1'b0) begin
         errors++;
         $display("FAIL disabled_noreq mem_req=%0b stall=%0b exp 0 0", bus_if.mem_req, bus_if.stall);
      end
      step();
      checks++;
      if (bus_if.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL disabled_noreq2 mem_req=%0b exp 0", bus_if.mem_req);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      gaps = '{0, 0, 0, 0};
      beats[0] = 32'hA000_0001; beats[1] = 32'hA000_0002; beats[2] = 32'hA000_0003; beats[3] = 32'hA000_0004;
      do_refill(32'h0000_2000, 1, 1'b0, 2'b01, "b2b0");
      beats[0] = 32'hB000_0001; beats[1] = 32'hB000_0002; beats[2] = 32'hB000_0003; beats[3] = 32'hB000_0004;
      do_refill(32'h0000_301C, 1, 1'b0, 2'b10, "b2b1");
      beats[0] = 32'hC000_0001; beats[1] = 32'hC000_0002; beats[2] = 32'hC000_0003; beats[3] = 32'hC000_0004;
      do_refill(32'h8000_004F, 2, 1'b0, 2'b01, "b2b2");
      step();
      checks++;
      if (bus_if.stall !== 1'b0 || bus_if.refill_we !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end stall=%0b we=%0b exp 0 0", bus_if.stall, bus_if.refill_we);
      end
   endtask

   task automatic test_gaps_spurious();
      gaps = '{2, 0, 5, 1};
      beats[0] = 32'h1111_1111; beats[1] = 32'h2222_2222; beats[2] = 32'h3333_3333; beats[3] = 32'h4444_4444;
      do_refill(32'h0000_1234, 2, 1'b1, 2'b10, "gaps");
      gaps = '{0, 0, 0, 0};
   endtask

   task automatic test_reset_mid();
      beats[0] = 32'h5555_0000; beats[1] = 32'h5555_1111; beats[2] = 32'h5555_2222; beats[3] = 32'h5555_3333;
      do_refill(32'h0000_4440, 1, 1'b0, 2'b01, "pre_rst");
      step();
      bus_if.cache_en = 1'b1; bus_if.cachein_addr = 32'h0000_ABC8; bus_if.hit_en = 2'b00;
      step();
      bus_if.cache_en = 1'b0; bus_if.mem_gnt = 1'b1;
      for (int b = 0; b < 3; b++) begin
         step();
         bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = 32'h7777_0000 + b;
      end
      @(posedge clk);
      #2;
      bus_if.mem_rvalid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus_if.stall, bus_if.mem_req, bus_if.refill_we, bus_if.refill_done} !== 4'b0) begin
         errors++;
         $display("FAIL rst_mid_ctl stall/req/we/done=%b exp 0000",
                  {bus_if.stall, bus_if.mem_req, bus_if.refill_we, bus_if.refill_done});
      end
      checks++;
      if (bus_if.refill_data !== '0 || bus_if.refill_addr !== '0 || bus_if.mem_addr !== '0) begin
         errors++;
         $display("FAIL rst_mid_data data=%h addr=%h mem_addr=%h exp 0", bus_if.refill_data, bus_if.refill_addr, bus_if.mem_addr);
      end
      repeat (2) @(posedge clk);
      #4 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         bus_if.mem_rvalid = 1'b1; bus_if.mem_gnt = 1'b1; bus_if.mem_rdata = 32'hFFFF_0000;
         #1;
         checks++;
         if (bus_if.refill_we !== 1'b0 || bus_if.mem_req !== 1'b0 || bus_if.stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle%0d we=%0b req=%0b stall=%0b exp 0 0 0",
                     i, bus_if.refill_we, bus_if.mem_req, bus_if.stall);
         end
      end
      bus_if.mem_rvalid = 1'b0; bus_if.mem_gnt = 1'b0;
      beats[0] = 32'h9999_0000; beats[1] = 32'h9999_1111; beats[2] = 32'h9999_2222; beats[3] = 32'h9999_3333;
      do_refill(32'h0000_ABC8, 1, 1'b0, 2'b01, "post_rst");
   endtask

`ifdef CACHE_REFILL_TIMEOUT_EN
   task automatic test_timeout();
      step();
      bus_if.cache_en = 1'b1; bus_if.cachein_addr = 32'h0000_6660; bus_if.hit_en = 2'b00;
      for (int c = 0; c < 10; c++) begin
         step();
         bus_if.cache_en = 1'b0; bus_if.mem_gnt = 1'b0;
         #1;
         checks++;
         if (bus_if.mem_req !== 1'b1 || bus_if.refill_err !== 1'b0) begin
            errors++;
            $display("FAIL to_req%0d mem_req=%0b err=%0b exp 1 0", c, bus_if.mem_req, bus_if.refill_err);
         end
      end
      step();
      checks++;
      if (bus_if.refill_err !== 1'b1 || bus_if.mem_req !== 1'b0 || bus_if.refill_we !== 1'b0 ||
          bus_if.refill_done !== 1'b0 || bus_if.stall !== 1'b0) begin
         errors++;
         $display("FAIL to_abort err=%0b req=%0b we=%0b done=%0b stall=%0b exp 1 0 0 0 0",
                  bus_if.refill_err, bus_if.mem_req, bus_if.refill_we, bus_if.refill_done, bus_if.stall);
      end
      step();
      checks++;
      if (bus_if.refill_err !== 1'b0) begin
         errors++;
         $display("FAIL to_pulse err=%0b exp 0", bus_if.refill_err);
      end
      beats[0] = 32'hE000_0000; beats[1] = 32'hE000_0001; beats[2] = 32'hE000_0002; beats[3] = 32'hE000_0003;
      do_refill(32'h0000_6660, 1, 1'b0, 2'b10, "after_to");
   endtask
`endif

   initial begin
      gaps = '{0, 0, 0, 0};
      test_reset();
      test_single_refill();
      test_hit();
      test_back_to_back();
      test_gaps_spurious();
      test_reset_mid();
`ifdef CACHE_REFILL_TIMEOUT_EN
      test_timeout();
`endif
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Multi-beat, stateful cache-miss refill controller between the cache tag/data arrays and main memory.
- On a miss it issues a line-aligned read request, collects BEATS memory beats into a line buffer, then writes the full line into a round-robin victim way.
- Stalls the core for the whole refill.
- Parametrised successor of the single-cycle combinational miss path: generalised line width, bus width and way count, with a req/gnt handshake.

Parameters:
ADDR_WIDTH, 32, byte address width
LINE_WIDTH, 128, cache line width in bits
MEM_DATA_WIDTH, 32, main-memory read beat width; LINE_WIDTH must be an integer multiple of it
WAY_NUM, 2, number of cache ways (>=1)
TIMEOUT_CYCLES, 255, refill watchdog limit (used only with optional feature)
Derived: BEATS = LINE_WIDTH/MEM_DATA_WIDTH; OFFSET_BITS = log2(LINE_WIDTH/8)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cache_en  in  1  access valid this cycle
cachein_addr  in  ADDR_WIDTH  access byte address
hit_en  in  WAY_NUM  per-way hit vector; all-zero with cache_en=1 means miss
stall  out  1  hold core pipeline
mem_req  out  1  read request to main memory
mem_addr  out  ADDR_WIDTH  line-aligned request address
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read beat valid
mem_rdata  in  MEM_DATA_WIDTH  read beat data
refill_we  out  1  write line into cache arrays
refill_way  out  WAY_NUM  one-hot victim way
refill_addr  out  ADDR_WIDTH  line-aligned address for tag/index
refill_data  out  LINE_WIDTH  assembled line
refill_done  out  1  one-cycle pulse, refill complete
refill_err  out  1  one-cycle pulse, refill aborted (optional feature)

Behaviour:
Reset (rst_n=0, asynchronous): state=IDLE; line buffer, line address, beat counter and round-robin pointer cleared to 0. All outputs 0.
Miss: miss = cache_en & (hit_en == 0).
stall is combinational: 1 when state != IDLE, or when state == IDLE and miss = 1.

IDLE
- On miss: latch line_addr = {cachein_addr[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'b0}, then go to REQ.
- Otherwise stay in IDLE.

REQ
- mem_req=1; mem_addr=line_addr, held stable until mem_gnt.
- On mem_gnt=1: mem_req deasserts next cycle, beat_cnt=0, go to FILL.

FILL
- mem_req=0.
- Each cycle with mem_rvalid=1: store mem_rdata into line buffer slice [beat_cnt*MEM_DATA_WIDTH +: MEM_DATA_WIDTH], then increment beat_cnt. Beat 0 occupies the LSBs.
- When beat BEATS-1 is stored, go to WRITE.
- Cycles without rvalid wait indefinitely (unless the optional feature is enabled).

WRITE (exactly one cycle)
- refill_we=1, refill_done=1, refill_addr=line_addr, refill_data=line buffer, refill_way=one-hot(rr_ptr).
- rr_ptr advances, wrapping WAY_NUM-1 -> 0.
- Next state is IDLE.
- With WAY_NUM=1, refill_way is always 1.

Outputs outside WRITE: refill_we, refill_done and refill_way are 0; refill_addr and refill_data hold their last values.

Boundary rules
- mem_rvalid outside FILL is ignored.
- mem_gnt outside REQ is ignored.
- cache_en, hit_en and cachein_addr are ignored outside IDLE.
- A new miss can start in the IDLE cycle immediately after WRITE (minimum 1 idle cycle between refills).
- Reset asserted mid-refill aborts it: no refill_we, rr_ptr returns to 0.

Optional Feature:
Macro CACHE_REFILL_TIMEOUT_EN.
- Defined: a watchdog counter clears on IDLE->REQ and increments every cycle in REQ/FILL. When it reaches TIMEOUT_CYCLES before WRITE:
  - refill_err=1 for one cycle;
  - state goes to IDLE with no refill_we and no refill_done;
  - rr_ptr unchanged;
  - line buffer contents are don't-care.
- Undefined: no counter is generated; refill_err is tied to 0 and refill waits forever.

Test Plan:
Defaults, miss at cachein_addr=0x0000_1234, hit_en=0 -> stall=1 same cycle; mem_req=1 next cycle with mem_addr=0x0000_1230.
mem_gnt after 3 cycles of req, then rvalid beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> refill_we=1 one cycle, refill_data=0x44444444_33333333_22222222_11111111, refill_addr=0x0000_1230, refill_way=2'b01; stall drops the cycle after WRITE.
Three back-to-back misses -> refill_way sequence 01, 10, 01; hit (hit_en=2'b10, cache_en=1) -> no mem_req, stall=0.
Beats with rvalid gaps of 0-5 cycles plus a spurious rvalid during REQ -> the spurious beat is ignored and the same line is assembled correctly.
rst_n pulsed low after beat 2 -> outputs 0 immediately, no refill_we; next miss uses refill_way=01.
With CACHE_REFILL_TIMEOUT_EN and TIMEOUT_CYCLES=10, mem_gnt never asserted -> refill_err pulses after 10 REQ cycles, state IDLE, no refill_we; next refill still uses the unadvanced way.
